// File: rtl/gate_truth_table_checker.sv
// Stimulus/response engine for small combinational gates: walks every input
// vector onto DRV, waits for Z to settle, and scores Z against a truth table.
module gate_truth_table_checker #(
  parameter int unsigned          N_IN          = 2,
  parameter int unsigned          SETTLE_CYCLES = 2,
  parameter logic [(1<<N_IN)-1:0] EXPECTED      = 4'b1000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] DRV,
  input  logic            Z,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            fail_valid,
  output logic [N_IN-1:0] fail_vec
);

  localparam int unsigned CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [N_IN-1:0] drv_q;
  logic            busy_q;
  logic            done_q;
  logic            pass_q;
  logic [N_IN:0]   err_q;
  logic [N_IN:0]   err_d;
  logic            fail_valid_q;
  logic [N_IN-1:0] fail_vec_q;
  logic            exp_bit;
  logic            mismatch;
  logic            last_vec;

  always_comb begin
    exp_bit  = EXPECTED[drv_q];
    // An unknown Z falls through to the mismatch path instead of being masked.
    mismatch = 1'b1;
    if (Z == exp_bit) mismatch = 1'b0;
    err_d    = err_q + {{N_IN{1'b0}}, mismatch};
    last_vec = (drv_q == '1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      drv_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      fail_vec_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            drv_q        <= '0;
            cnt_q        <= '0;
            busy_q       <= 1'b1;
            err_q        <= '0;
            fail_valid_q <= 1'b0;
            fail_vec_q   <= '0;
            pass_q       <= 1'b0;
            state_q      <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(SETTLE_CYCLES - 1)) state_q <= S_SAMPLE;
        end
        S_SAMPLE: begin
          if (mismatch) begin
            err_q <= err_d;
            if (!fail_valid_q) begin
              fail_valid_q <= 1'b1;
              fail_vec_q   <= drv_q;
            end
          end
          if (last_vec) begin
            done_q  <= 1'b1;
            pass_q  <= (err_d == '0);
            state_q <= S_DONE;
          end else begin
            drv_q   <= drv_q + 1'b1;
            cnt_q   <= '0;
            state_q <= S_SETTLE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign DRV        = drv_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_valid = fail_valid_q;
  assign fail_vec   = fail_vec_q;

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Directed bench for gate_truth_table_checker: three instances covering the
// AND2 default, a NAND table with continuous start, and a 3-input AND.
module tb_gate_truth_table_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Instance A: default AND2 table, Z from a selectable gate model
  logic       start_a = 1'b0;
  logic [1:0] drv_a;
  logic       z_a;
  logic       busy_a, done_a, pass_a, fv_a;
  logic [2:0] err_a;
  logic [1:0] fvec_a;
  int         mode = 0;  // 0 AND-from-NANDs, 1 OR, 2 stuck-0, 3 stuck-1

  always_comb begin
    case (mode)
      0:       z_a = ~(~(drv_a[0] & drv_a[1]) & ~(drv_a[0] & drv_a[1]));
      1:       z_a = drv_a[0] | drv_a[1];
      2:       z_a = 1'b0;
      default: z_a = 1'b1;
    endcase
  end

  gate_truth_table_checker u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .DRV(drv_a), .Z(z_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
    .fail_valid(fv_a), .fail_vec(fvec_a)
  );

  // Instance N: NAND2 table
  logic       start_n = 1'b0;
  logic [1:0] drv_n;
  logic       busy_n, done_n, pass_n, fv_n;
  logic [2:0] err_n;
  logic [1:0] fvec_n;
  wire        z_n = ~(drv_n[0] & drv_n[1]);

  gate_truth_table_checker #(.N_IN(2), .SETTLE_CYCLES(2), .EXPECTED(4'b0111)) u_dut_n (
    .clk(clk), .rst_n(rst_n), .start(start_n), .DRV(drv_n), .Z(z_n),
    .busy(busy_n), .done(done_n), .pass(pass_n), .err_count(err_n),
    .fail_valid(fv_n), .fail_vec(fvec_n)
  );

  // Instance 3: 3-input AND, one settle cycle
  logic       start_3 = 1'b0;
  logic [2:0] drv_3;
  logic       busy_3, done_3, pass_3, fv_3;
  logic [3:0] err_3;
  logic [2:0] fvec_3;
  wire        z_3 = &drv_3;

  gate_truth_table_checker #(.N_IN(3), .SETTLE_CYCLES(1), .EXPECTED(8'h80)) u_dut_3 (
    .clk(clk), .rst_n(rst_n), .start(start_3), .DRV(drv_3), .Z(z_3),
    .busy(busy_3), .done(done_3), .pass(pass_3), .err_count(err_3),
    .fail_valid(fv_3), .fail_vec(fvec_3)
  );

  // Runs one sweep on instance A; cyc = edges from acceptance to done (0 on timeout)
  task automatic sweep_a(input int m, input bit chk_drv, output int cyc);
    mode = m;
    cyc  = 0;
    @(negedge clk) start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    check("accept_busy", busy_a, 1);
    check("accept_drv", drv_a, 0);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (chk_drv && (k % 3 == 1)) check($sformatf("drv_k%0d", k), drv_a, k / 3);
      if (done_a) begin
        cyc = k;
        break;
      end
    end
    check("done_seen", (cyc != 0), 1);
  endtask

  task automatic results_a(input string t, input int e, input int fv, input int fvec, input int p);
    check({t, "_err"}, err_a, e);
    check({t, "_fvalid"}, fv_a, fv);
    if (fv != 0) check({t, "_fvec"}, fvec_a, fvec);
    check({t, "_pass"}, pass_a, p);
  endtask

  initial begin
    int cyc;
    int last_done;
    int ndone;

    #2;
    check("rst_drv", drv_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_pass", pass_a, 0);
    check("rst_err", err_a, 0);
    check("rst_fvalid", fv_a, 0);
    check("rst_fvec", fvec_a, 0);
    @(negedge clk) rst_n = 1'b1;

    // T1: AND from NANDs
    sweep_a(0, 1'b1, cyc);
    check("t1_latency", cyc, 12);
    check("t1_drv_last", drv_a, 3);
    results_a("t1", 0, 0, 0, 1);
    @(posedge clk); #1;
    check("t1_done_pulse", done_a, 0);
    check("t1_busy_off", busy_a, 0);
    check("t1_drv_hold", drv_a, 3);
    check("t1_pass_hold", pass_a, 1);

    // T2: OR against the AND table
    sweep_a(1, 1'b0, cyc);
    check("t2_latency", cyc, 12);
    results_a("t2", 2, 1, 1, 0);
    @(posedge clk); #1;

    // T3: stuck-at faults
    sweep_a(2, 1'b0, cyc);
    results_a("t3s0", 1, 1, 3, 0);
    @(posedge clk); #1;
    sweep_a(3, 1'b0, cyc);
    results_a("t3s1", 3, 1, 0, 0);
    @(posedge clk); #1;

    // T4: reset during vector 2 settle, then a clean sweep
    mode = 0;
    @(negedge clk) start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("t4_pre_drv", drv_a, 2);
    check("t4_pre_busy", busy_a, 1);
    rst_n = 1'b0;
    #1;
    check("t4_rst_drv", drv_a, 0);
    check("t4_rst_busy", busy_a, 0);
    check("t4_rst_err", err_a, 0);
    check("t4_rst_fvalid", fv_a, 0);
    check("t4_rst_pass", pass_a, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("t4_no_resume", busy_a, 0);
    sweep_a(0, 1'b1, cyc);
    check("t4_latency", cyc, 12);
    results_a("t4", 0, 0, 0, 1);
    @(posedge clk); #1;

    // T5: start held high; one DONE and one IDLE cycle between sweeps
    ndone = 0;
    last_done = -1;
    @(negedge clk) start_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done_n) begin
        ndone++;
        check("t5_pass", pass_n, 1);
        check("t5_err", err_n, 0);
        if (last_done < 0) check("t5_first_done", i, 12);
        else check("t5_period", i - last_done, 14);
        last_done = i;
      end
    end
    check("t5_ndone", ndone, 2);
    start_n = 1'b0;

    // T6: 3-input AND, SETTLE_CYCLES=1
    cyc = 0;
    @(negedge clk) start_3 = 1'b1;
    @(posedge clk); #1;
    start_3 = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done_3) begin
        cyc = k;
        break;
      end
    end
    check("t6_latency", cyc, 16);
    check("t6_pass", pass_3, 1);
    check("t6_err", err_3, 0);
    check("t6_fvalid", fv_3, 0);
    check("t6_drv_last", drv_3, 7);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
